// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the serial sequencers: 2-bit state encodings and a start-acceptance helper.
package serial_adder_ctrl_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // A new request is accepted only when no operation is in flight.
    function automatic logic accepts_start(input logic [ST_W-1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial sequencer.
module serial_adder_ctrl_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, WIDTH cycles per sum, start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] w_sum_sr_nxt;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_fa_s;
    logic             w_fa_cout;

    serial_adder_ctrl_full_adder u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    // State register; busy/done are registered alongside so they track state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_nxt = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath controls and next values of the status flags.
    always_comb begin
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_last     = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_load     = accepts_start(r_state) && start;
        w_step     = (r_state == ST_RUN);
        w_last     = w_step && (r_cnt == CNT_W'(WIDTH - 1));
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign w_sum_sr_nxt = WIDTH'({w_fa_s, r_sum_sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_sr_nxt;
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Result is committed only on the final bit, so partial sums never appear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_sum_sr_nxt;
            r_cout <= w_fa_cout;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances with hand-computed results.
module tb_serial_adder_ctrl;

    localparam logic [9:0] EXP_BUSY = 10'b01_1111_1110;
    localparam logic [9:0] EXP_DONE = 10'b10_0000_0000;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       w1_start;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_cin;
    logic       w1_busy;
    logic       w1_done;
    logic [0:0] w1_sum;
    logic       w1_cout;

    int n_checks;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(w1_start), .a(w1_a), .b(w1_b), .cin(w1_cin),
        .busy(w1_busy), .done(w1_done), .sum(w1_sum), .cout(w1_cout)
    );

    always #5 clk = ~clk;

    // Drives one WIDTH=8 operation from the current negedge and records what the DUT shows each cycle.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                           input bit hold, input logic [7:0] na, input logic [7:0] nb,
                           output logic [9:0] btr, output logic [9:0] dtr,
                           output logic [7:0] first_mid, output bit stable,
                           output logic [7:0] rs, output logic rc);
        start = 1'b1; a = ta; b = tb_; cin = tcin;
        btr = '0; dtr = '0; stable = 1'b1; first_mid = '0; rs = '0; rc = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            btr[4'(c)] = busy;
            dtr[4'(c)] = done;
            if (c == 1) first_mid = sum;
            else if (c <= 8 && sum !== first_mid) stable = 1'b0;
            if (c == 9) begin rs = sum; rc = cout; end
            if (!hold || c == 9) start = 1'b0;
            if (c == 1 && !hold) begin a = ~ta; b = ~tb_; cin = ~tcin; end
            if (c == 4 && hold) begin a = na; b = nb; cin = ~tcin; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_fail++; $display("FAIL reset_w8 got=%b exp=0", {busy, done, sum, cout});
        end
        n_checks++;
        if ({w1_busy, w1_done, w1_sum, w1_cout} !== 4'd0) begin
            n_fail++; $display("FAIL reset_w1 got=%b exp=0", {w1_busy, w1_done, w1_sum, w1_cout});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_basic();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        run_op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (btr !== EXP_BUSY) begin n_fail++; $display("FAIL basic_busy got=%b exp=%b", btr, EXP_BUSY); end
        n_checks++;
        if (dtr !== EXP_DONE) begin n_fail++; $display("FAIL basic_done got=%b exp=%b", dtr, EXP_DONE); end
        n_checks++;
        if (rs !== 8'h96 || rc !== 1'b0) begin
            n_fail++; $display("FAIL basic_sum got=%h/%b exp=96/0", rs, rc);
        end
        n_checks++;
        if (fm !== 8'h00 || st !== 1'b1) begin
            n_fail++; $display("FAIL basic_no_partial got=%h stable=%0d exp=00 stable=1", fm, st);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, sum} !== {2'b00, 8'h96}) begin
            n_fail++; $display("FAIL basic_idle_hold got=%b/%h exp=00/96", {busy, done}, sum);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (rs !== 8'h00 || rc !== 1'b1) begin n_fail++; $display("FAIL ovf_ff_01 got=%h/%b exp=00/1", rs, rc); end
        n_checks++;
        if (fm !== 8'h96) begin n_fail++; $display("FAIL ovf_prev_held got=%h exp=96", fm); end
        @(negedge clk);
        run_op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (rs !== 8'h00 || rc !== 1'b1) begin n_fail++; $display("FAIL ovf_ff_cin got=%h/%b exp=00/1", rs, rc); end
        n_checks++;
        if (dtr !== EXP_DONE) begin n_fail++; $display("FAIL ovf_done got=%b exp=%b", dtr, EXP_DONE); end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        run_op8(8'h21, 8'h42, 1'b1, 1'b1, 8'hF0, 8'hF0, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (btr !== EXP_BUSY) begin n_fail++; $display("FAIL held_busy got=%b exp=%b", btr, EXP_BUSY); end
        n_checks++;
        if (dtr !== EXP_DONE) begin n_fail++; $display("FAIL held_done got=%b exp=%b", dtr, EXP_DONE); end
        n_checks++;
        if (rs !== 8'h64 || rc !== 1'b0) begin n_fail++; $display("FAIL held_sum got=%h/%b exp=64/0", rs, rc); end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL held_single_done got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        run_op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (rs !== 8'h96) begin n_fail++; $display("FAIL b2b_first got=%h exp=96", rs); end
        run_op8(8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (btr !== EXP_BUSY) begin n_fail++; $display("FAIL b2b_busy got=%b exp=%b", btr, EXP_BUSY); end
        n_checks++;
        if (dtr !== EXP_DONE) begin n_fail++; $display("FAIL b2b_done got=%b exp=%b", dtr, EXP_DONE); end
        n_checks++;
        if (fm !== 8'h96 || st !== 1'b1) begin
            n_fail++; $display("FAIL b2b_prev_held got=%h stable=%0d exp=96 stable=1", fm, st);
        end
        n_checks++;
        if (rs !== 8'h03 || rc !== 1'b0) begin n_fail++; $display("FAIL b2b_sum got=%h/%b exp=03/0", rs, rc); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        int busy_cnt, done_cnt;
        run_op8(8'hF0, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (rs !== 8'h10 || rc !== 1'b1) begin n_fail++; $display("FAIL areset_pre got=%h/%b exp=10/1", rs, rc); end
        @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_fail++; $display("FAIL areset_immediate got=%b/%h/%b exp=00/00/0", {busy, done}, sum, cout);
        end
        @(negedge clk); rst = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (busy_cnt != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL areset_no_done got busy=%0d done=%0d exp 0/0", busy_cnt, done_cnt);
        end
        run_op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
        n_checks++;
        if (rs !== 8'h30 || rc !== 1'b0 || fm !== 8'h00) begin
            n_fail++; $display("FAIL areset_after got=%h/%b prev=%h exp=30/0 prev=00", rs, rc, fm);
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic b1, d1, b2, d2;
        w1_start = 1'b1; w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1;
        @(negedge clk);
        b1 = w1_busy; d1 = w1_done;
        w1_start = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
        @(negedge clk);
        b2 = w1_busy; d2 = w1_done;
        n_checks++;
        if ({b1, d1, b2, d2} !== 4'b1001) begin
            n_fail++; $display("FAIL w1_timing got=%b exp=1001", {b1, d1, b2, d2});
        end
        n_checks++;
        if (w1_sum !== 1'b1 || w1_cout !== 1'b1) begin
            n_fail++; $display("FAIL w1_sum got=%b/%b exp=1/1", w1_sum, w1_cout);
        end
        @(negedge clk);
        n_checks++;
        if ({w1_busy, w1_done} !== 2'b00) begin
            n_fail++; $display("FAIL w1_idle got=%b exp=00", {w1_busy, w1_done});
        end
    endtask

    task automatic test_random();
        logic [9:0] btr, dtr; logic [7:0] fm, rs; bit st; logic rc;
        logic [7:0] ra, rb; logic rci; logic [8:0] exp; logic [7:0] prev;
        prev = 8'h30;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rci);
            run_op8(ra, rb, rci, 1'b0, 8'h00, 8'h00, btr, dtr, fm, st, rs, rc);
            n_checks++;
            if ({rc, rs} !== exp) begin
                n_fail++; $display("FAIL rand_%0d %h+%h+%b got=%h exp=%h", i, ra, rb, rci, {rc, rs}, exp);
            end
            n_checks++;
            if (btr !== EXP_BUSY || dtr !== EXP_DONE) begin
                n_fail++; $display("FAIL rand_hs_%0d got=%b/%b exp=%b/%b", i, btr, dtr, EXP_BUSY, EXP_DONE);
            end
            n_checks++;
            if (fm !== prev || st !== 1'b1) begin
                n_fail++; $display("FAIL rand_held_%0d got=%h stable=%0d exp=%h", i, fm, st, prev);
            end
            prev = exp[7:0];
            if (i % 2 == 0) @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        w1_start = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_width1();
        test_basic();
        test_overflow();
        test_start_held();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It computes a WIDTH-bit sum with carry-out by time-multiplexing a single 1-bit full_adder cell over WIDTH clock cycles. A start/busy/done handshake lets a small datapath trade area for latency. It sits between a requesting control FSM and the shared 1-bit adder cell, and owns the operand shift registers, the carry flop and the bit counter.

Parameters:
- WIDTH, default 8, operand and sum width in bits; legal range 1 to 64.
- CNT_W, default $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk, input, 1, single clock; all flops rising-edge.
- rst, input, 1, asynchronous, active-high reset; clears all state.
- start, input, 1, request pulse; sampled only in IDLE or DONE.
- a, input, WIDTH, operand A; captured on the accepted start edge.
- b, input, WIDTH, operand B; captured on the accepted start edge.
- cin, input, 1, carry-in; captured on the accepted start edge.
- busy, output, 1, high while the addition is running (RUN state).
- done, output, 1, one-cycle pulse; sum and cout are valid from this cycle.
- sum, output, WIDTH, registered result; held until the next completion or reset.
- cout, output, 1, registered final carry-out; held with sum.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0; done=0; sum=0; cout=0; shift regs, carry flop and counter all 0. Reset deasserts synchronously into IDLE.
- States:
  - IDLE=2'd0: waiting for a request.
  - RUN=2'd1: one bit processed per cycle.
  - DONE=2'd2: one-cycle completion state.
  - Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- IDLE to RUN on start=1:
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0.
  - sum_sr is don't-care.
- RUN, each edge:
  - full_adder inputs: a_sr[0], b_sr[0], carry.
  - a_sr and b_sr shift right by 1.
  - sum_sr shifts right, with the cell's s entering the MSB.
  - carry<=cell cout; cnt<=cnt+1.
- RUN to DONE on the edge where cnt==WIDTH-1, which processes the last bit.
  - On that same edge, sum<=final sum_sr value (including the last bit) and cout<=cell cout.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE: go directly to RUN with a fresh load (back-to-back, no idle bubble).
  - otherwise: go to IDLE.
- Timing: start sampled high at the end of cycle 0 gives busy=1 in cycles 1..WIDTH and done=1 in cycle WIDTH+1. Latency is WIDTH+1 cycles; throughput is one result per WIDTH+1 cycles.
- busy=(state==RUN); done=(state==DONE). Both are decoded from registered state, so they are glitch-free.
- start in RUN is ignored, not queued. a, b and cin may change freely after the start edge.
- sum and cout change only on the RUN-to-DONE edge or on reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only through cout.
- WIDTH=1: RUN lasts exactly one cycle and done appears in cycle 2.
- Reset during RUN or DONE: the operation is abandoned, no done pulse is produced, and sum/cout return to 0.

Decomposition:
- Shared constants header: state encodings IDLE/RUN/DONE as 2-bit localparams, reused by other serial sequencers.
- One sub-module: the existing full_adder cell (a, b, cin to s, cout), instantiated once. All other logic is local to serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start in cycle 0 -> busy high in cycles 1-8, done in cycle 9, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- start held high throughout RUN, with operands changed mid-run -> no restart; result equals the operands captured in cycle 0; exactly one done pulse.
- start asserted in the DONE cycle with a=8'h01, b=8'h02 -> RUN begins the next cycle (no IDLE); done 9 cycles later with sum=8'h03. The previous sum stays held until then.
- rst asserted asynchronously mid-cycle at cycle 4 of RUN -> busy, done, sum and cout go to 0 immediately; no done pulse. A subsequent start gives a correct result (8'h10+8'h20 gives 8'h30).
- WIDTH=1 build: a=1, b=1, cin=1 -> done in cycle 2, sum=1, cout=1. Also a randomized check of 1000 WIDTH=8 operations against a+b+cin.
